// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg : shared width helpers and read-mode encodings for param_sync_fifo
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  // Read-mode encodings for the FWFT parameter
  localparam int FWFT_STD         = 0;
  localparam int FWFT_FALLTHROUGH = 1;

  // Memory address width for a given depth
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Pointer / count width: one extra bit so full and empty are distinguishable
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// ----------------------------------------------------------------------------
// fifo_mem : DEPTH x DATA_WIDTH register array, synchronous write, async read
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [addr_width(DEPTH)-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic [addr_width(DEPTH)-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately left unreset; pointers alone define validity
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/param_sync_fifo.sv
// ----------------------------------------------------------------------------
// param_sync_fifo : single-clock FIFO with level flags and sticky error flags
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = FWFT_STD
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         clr_err,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         FULL,
  output logic                         EMPTY,
  output logic                         ALMOST_FULL,
  output logic                         ALMOST_EMPTY,
  output logic [ptr_width(DEPTH)-1:0]  count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int ADDR_W = addr_width(DEPTH);
  localparam int PTR_W  = ptr_width(DEPTH);

  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0] ONE_C   = PTR_W'(1);

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] rd_data;

  // Flags come straight from the count register, never from wr_en/rd_en
  assign FULL         = (count == DEPTH_C);
  assign EMPTY        = (count == '0);
  assign ALMOST_FULL  = (count >= AF_C);
  assign ALMOST_EMPTY = (count <= AE_C);

  // A simultaneous read frees the slot a write into a full FIFO needs,
  // but a simultaneous write never makes a read from empty legal.
  assign rd_ok = rd_en && !EMPTY;
  assign wr_ok = wr_en && (!FULL || rd_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ONE_C;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + ONE_C;
      end

      case ({wr_ok, rd_ok})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase

      // Set takes priority over a coincident clear
      if (wr_en && !wr_ok) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end

      if (rd_en && !rd_ok) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (data_in),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  generate
    if (FWFT == FWFT_FALLTHROUGH) begin : g_fwft
      // Head entry is visible combinationally; forced to zero while empty
      assign data_out = EMPTY ? '0 : rd_data;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
        end else if (rd_ok) begin
          dout_q <= rd_data;
        end
      end

      assign data_out = dout_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
// ----------------------------------------------------------------------------
// tb_param_sync_fifo : scoreboard bench for param_sync_fifo (standard + FWFT)
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_param_sync_fifo;

  localparam int DW    = 6;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clr_err;
  logic          wr_en, rd_en;
  logic [DW-1:0] data_in, data_out;
  logic          full, empty, afull, aempty, overflow, underflow;
  logic [CW-1:0] count;

  logic          wr1, rd1;
  logic [DW-1:0] d1, dout1;
  logic          full1, empty1, afull1, aempty1, ovf1, unf1;
  logic [CW-1:0] count1;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mq[$];
  bit            pend = 1'b0;

  logic [DW-1:0] words [8] = '{6'h2A, 6'h15, 6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};

  param_sync_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)
  ) dut_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .clr_err(clr_err), .data_out(data_out), .FULL(full), .EMPTY(empty),
    .ALMOST_FULL(afull), .ALMOST_EMPTY(aempty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  param_sync_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)
  ) dut_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr1), .rd_en(rd1), .data_in(d1),
    .clr_err(clr_err), .data_out(dout1), .FULL(full1), .EMPTY(empty1),
    .ALMOST_FULL(afull1), .ALMOST_EMPTY(aempty1), .count(count1),
    .overflow(ovf1), .underflow(unf1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the expected read word is queued as it is issued
  task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input bit clr);
    bit rd_ok, wr_ok;
    wr_en = w; rd_en = r; data_in = d; clr_err = clr;
    rd_ok = r && (mq.size() > 0);
    wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
    if (rd_ok) exp_q.push_back(mq.pop_front());
    if (wr_ok) mq.push_back(d);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  // Monitor: a read accepted at an edge presents its word for the next cycle
  always @(posedge clk) pend <= rst_n && rd_en && !empty;

  always @(negedge clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dout_unexpected: got 0x%0h, expected no read data", data_out);
      end else begin
        check("dout", data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clr_err = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    wr1 = 1'b0; rd1 = 1'b0; d1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty",  empty,     1);
    check("rst_aempty", aempty,    1);
    check("rst_full",   full,      0);
    check("rst_afull",  afull,     0);
    check("rst_count",  count,     0);
    check("rst_dout",   data_out,  0);
    check("rst_ovf",    overflow,  0);
    check("rst_unf",    underflow, 0);
    check("rst_empty1", empty1,    1);
    check("rst_dout1",  dout1,     0);
    rst_n = 1'b1;

    // Read from empty
    step(0, 1, '0, 0);
    check("uf_flag",  underflow, 1);
    check("uf_empty", empty,     1);
    check("uf_count", count,     0);
    check("uf_dout",  data_out,  0);

    // Fill, watching the level flags step by step
    for (int i = 0; i < 8; i++) begin
      step(1, 0, words[i], 0);
      check("fill_count",  count,  i + 1);
      check("fill_afull",  afull,  (i >= 5) ? 1 : 0);
      check("fill_full",   full,   (i == 7) ? 1 : 0);
      check("fill_aempty", aempty, (i <= 1) ? 1 : 0);
    end
    check("fill_ovf", overflow, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, DW'(6'h3F - i), 0);
      check("ovf_flag",  overflow, 1);
      check("ovf_count", count,    8);
    end

    step(0, 0, '0, 1);
    check("clr_ovf",   overflow,  0);
    check("clr_unf",   underflow, 0);
    check("clr_count", count,     8);

    // Drain in order
    for (int i = 0; i < 8; i++) begin
      step(0, 1, '0, 0);
      check("drain_count",  count,  7 - i);
      check("drain_aempty", aempty, (7 - i <= 2) ? 1 : 0);
      check("drain_empty",  empty,  (i == 7) ? 1 : 0);
    end
    step(0, 0, '0, 0);
    check("drain_sb", exp_q.size(), 0);

    // Refill, then stream through a full FIFO across pointer wrap
    for (int i = 0; i < 8; i++) step(1, 0, DW'(8'h30 + i), 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, DW'(8'h38 + i), 0);
      check("stream_count", count, 8);
      check("stream_full",  full,  1);
    end
    check("stream_ovf", overflow, 0);

    repeat (3) step(0, 1, '0, 0);
    step(0, 0, '0, 0);
    check("pre_rst_count", count, 5);

    // Asynchronous reset in the middle of a cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count",  count,    0);
    check("arst_empty",  empty,    1);
    check("arst_aempty", aempty,   1);
    check("arst_full",   full,     0);
    check("arst_afull",  afull,    0);
    check("arst_dout",   data_out, 0);
    mq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    step(0, 1, '0, 0);
    check("post_unf", underflow, 1);
    step(1, 0, 6'h11, 0);
    step(1, 0, 6'h22, 0);
    check("post_count", count, 2);
    step(0, 0, '0, 1);
    check("clr_only_unf",   underflow, 0);
    check("clr_only_count", count,     2);
    step(0, 1, '0, 0);
    step(0, 1, '0, 0);
    step(0, 1, '0, 1);
    check("set_wins_unf", underflow, 1);
    step(0, 0, '0, 0);

    // First-word-fall-through instance
    wr1 = 1'b1; d1 = 6'h33;
    @(posedge clk); #1;
    wr1 = 1'b0;
    check("fwft_empty", empty1, 0);
    check("fwft_dout",  dout1,  6'h33);
    check("fwft_count", count1, 1);
    @(posedge clk); #1;
    check("fwft_hold", dout1, 6'h33);
    wr1 = 1'b1; d1 = 6'h0C;
    @(posedge clk); #1;
    wr1 = 1'b0;
    check("fwft_head",   dout1,  6'h33);
    check("fwft_count2", count1, 2);
    rd1 = 1'b1;
    @(posedge clk); #1;
    rd1 = 1'b0;
    check("fwft_next",   dout1,  6'h0C);
    check("fwft_count3", count1, 1);

    check("final_sb", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
